// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter (EXU vs LSU) with a 32-entry pending-write scoreboard.
// Define WB_ARB_RR_EN for round-robin tie-breaking; otherwise LSU has fixed priority.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        decode_i_issue_valid,
    input  logic [4:0]  decode_i_issue_rd,
    output logic        decode_o_issue_ready,
    input  logic [4:0]  decode_i_reg_rs1,
    input  logic [4:0]  decode_i_reg_rs2,
    output logic        decode_o_rs1_busy,
    output logic        decode_o_rs2_busy,
    input  logic        exu_i_valid,
    input  logic [4:0]  exu_i_rd,
    input  logic [31:0] exu_i_data,
    output logic        exu_o_ready,
    input  logic        lsu_i_valid,
    input  logic [4:0]  lsu_i_rd,
    input  logic [31:0] lsu_i_data,
    output logic        lsu_o_ready,
    output logic        wb_o_reg_wen,
    output logic [4:0]  wb_o_reg_rd,
    output logic [31:0] wb_o_reg_data
);

    // Handshake: a requester raises valid and holds rd/data stable; ready is a
    // combinational function of the valids and is the grant. Transfer on valid&&ready.
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        exu_wins_tie;
    logic        grant_exu;
    logic        grant_lsu;
    logic        issue_fire;

`ifdef WB_ARB_RR_EN
    // Set when the last contended grant went to EXU, so LSU wins the next tie.
    logic lsu_pref;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsu_pref <= 1'b0;
        end else if (exu_i_valid && lsu_i_valid) begin
            lsu_pref <= grant_exu;
        end
    end

    assign exu_wins_tie = !lsu_pref;
`else
    assign exu_wins_tie = 1'b0;
`endif

    always_comb begin
        grant_exu = exu_i_valid && (!lsu_i_valid || exu_wins_tie);
        grant_lsu = lsu_i_valid && !grant_exu;
    end

    assign exu_o_ready = grant_exu;
    assign lsu_o_ready = grant_lsu;

    assign decode_o_issue_ready = !pending[decode_i_issue_rd];
    assign decode_o_rs1_busy    = pending[decode_i_reg_rs1];
    assign decode_o_rs2_busy    = pending[decode_i_reg_rs2];
    assign issue_fire           = decode_i_issue_valid && decode_o_issue_ready;

    // Clear happens on the commit edge; a set cannot target the same bit because
    // issue is blocked while that bit is pending.
    always_comb begin
        pending_nxt = pending;
        if (wb_o_reg_wen) begin
            pending_nxt[wb_o_reg_rd] = 1'b0;
        end
        if (issue_fire && (decode_i_issue_rd != 5'd0)) begin
            pending_nxt[decode_i_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // An rd=0 grant is consumed here with wen held low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_o_reg_wen  <= 1'b0;
            wb_o_reg_rd   <= 5'd0;
            wb_o_reg_data <= 32'd0;
        end else begin
            wb_o_reg_wen <= 1'b0;
            if (grant_exu) begin
                wb_o_reg_wen  <= (exu_i_rd != 5'd0);
                wb_o_reg_rd   <= exu_i_rd;
                wb_o_reg_data <= exu_i_data;
            end else if (grant_lsu) begin
                wb_o_reg_wen  <= (lsu_i_rd != 5'd0);
                wb_o_reg_rd   <= lsu_i_rd;
                wb_o_reg_data <= lsu_i_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: expected regfile writes are queued when
// requests are driven and popped when the write port fires.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        decode_i_issue_valid;
    logic [4:0]  decode_i_issue_rd;
    logic        decode_o_issue_ready;
    logic [4:0]  decode_i_reg_rs1;
    logic [4:0]  decode_i_reg_rs2;
    logic        decode_o_rs1_busy;
    logic        decode_o_rs2_busy;
    logic        exu_i_valid;
    logic [4:0]  exu_i_rd;
    logic [31:0] exu_i_data;
    logic        exu_o_ready;
    logic        lsu_i_valid;
    logic [4:0]  lsu_i_rd;
    logic [31:0] lsu_i_data;
    logic        lsu_o_ready;
    logic        wb_o_reg_wen;
    logic [4:0]  wb_o_reg_rd;
    logic [31:0] wb_o_reg_data;

    int checks;
    int errors;
    logic [36:0] exp_q[$];
    logic [31:0] model_rf[32];

    regfile_wb_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .decode_i_issue_valid (decode_i_issue_valid),
        .decode_i_issue_rd    (decode_i_issue_rd),
        .decode_o_issue_ready (decode_o_issue_ready),
        .decode_i_reg_rs1     (decode_i_reg_rs1),
        .decode_i_reg_rs2     (decode_i_reg_rs2),
        .decode_o_rs1_busy    (decode_o_rs1_busy),
        .decode_o_rs2_busy    (decode_o_rs2_busy),
        .exu_i_valid          (exu_i_valid),
        .exu_i_rd             (exu_i_rd),
        .exu_i_data           (exu_i_data),
        .exu_o_ready          (exu_o_ready),
        .lsu_i_valid          (lsu_i_valid),
        .lsu_i_rd             (lsu_i_rd),
        .lsu_i_data           (lsu_i_data),
        .lsu_o_ready          (lsu_o_ready),
        .wb_o_reg_wen         (wb_o_reg_wen),
        .wb_o_reg_rd          (wb_o_reg_rd),
        .wb_o_reg_data        (wb_o_reg_data)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    end

    // Regfile model: commits whatever the write port presents at the edge.
    always @(posedge clk) begin
        if (wb_o_reg_wen === 1'b1) model_rf[wb_o_reg_rd] <= wb_o_reg_data;
    end

    // Scoreboard: compare each write-port transfer against the oldest expectation.
    always @(negedge clk) begin
        logic [36:0] exp_w;
        if (rst === 1'b1 && wb_o_reg_wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got rd=%0d data=%h, none expected", wb_o_reg_rd, wb_o_reg_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wb_o_reg_rd, wb_o_reg_data} !== exp_w) begin
                    errors++;
                    $display("FAIL wb_write got rd=%0d data=%h expected rd=%0d data=%h",
                             wb_o_reg_rd, wb_o_reg_data, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic idle_inputs();
        decode_i_issue_valid = 1'b0;
        decode_i_issue_rd    = 5'd0;
        decode_i_reg_rs1     = 5'd0;
        decode_i_reg_rs2     = 5'd0;
        exu_i_valid          = 1'b0;
        exu_i_rd             = 5'd0;
        exu_i_data           = 32'd0;
        lsu_i_valid          = 1'b0;
        lsu_i_rd             = 5'd0;
        lsu_i_data           = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wb_o_reg_wen !== 1'b0 || wb_o_reg_rd !== 5'd0 || wb_o_reg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got wen=%b rd=%0d data=%h expected 0/0/0",
                     wb_o_reg_wen, wb_o_reg_rd, wb_o_reg_data);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            decode_i_issue_rd = i[4:0];
            decode_i_reg_rs1  = i[4:0];
            decode_i_reg_rs2  = 5'(31 - i);
            #1;
            checks++;
            if (decode_o_issue_ready !== 1'b1 || decode_o_rs1_busy !== 1'b0 || decode_o_rs2_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle rd=%0d got ready=%b busy1=%b busy2=%b expected 1/0/0",
                         i, decode_o_issue_ready, decode_o_rs1_busy, decode_o_rs2_busy);
            end
        end
        @(negedge clk);
        exu_i_valid = 1'b1;
        #1;
        checks++;
        if (exu_o_ready !== 1'b1 || lsu_o_ready !== 1'b0) begin
            errors++;
            $display("FAIL lone_exu got exu_ready=%b lsu_ready=%b expected 1/0", exu_o_ready, lsu_o_ready);
        end
        exu_i_valid = 1'b0;
        lsu_i_valid = 1'b1;
        #1;
        checks++;
        if (exu_o_ready !== 1'b0 || lsu_o_ready !== 1'b1) begin
            errors++;
            $display("FAIL lone_lsu got exu_ready=%b lsu_ready=%b expected 0/1", exu_o_ready, lsu_o_ready);
        end
        lsu_i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_o_reg_wen !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_wen got %b expected 0", wb_o_reg_wen);
        end
    endtask

    task automatic test_issue_write();
        @(negedge clk);
        decode_i_issue_valid = 1'b1;
        decode_i_issue_rd    = 5'd5;
        decode_i_reg_rs1     = 5'd5;
        #1;
        checks++;
        if (decode_o_issue_ready !== 1'b1 || decode_o_rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL issue5_before got ready=%b busy=%b expected 1/0", decode_o_issue_ready, decode_o_rs1_busy);
        end
        @(negedge clk);
        decode_i_issue_valid = 1'b0;
        #1;
        checks++;
        if (decode_o_rs1_busy !== 1'b1 || decode_o_issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL issue5_after got busy=%b ready=%b expected 1/0", decode_o_rs1_busy, decode_o_issue_ready);
        end
        exu_i_valid = 1'b1;
        exu_i_rd    = 5'd5;
        exu_i_data  = 32'h1234_5678;
        exp_q.push_back({5'd5, 32'h1234_5678});
        #1;
        checks++;
        if (exu_o_ready !== 1'b1) begin
            errors++;
            $display("FAIL exu5_grant got %b expected 1", exu_o_ready);
        end
        @(posedge clk);
        #1;
        exu_i_valid = 1'b0;
        checks++;
        if (wb_o_reg_wen !== 1'b1 || wb_o_reg_rd !== 5'd5) begin
            errors++;
            $display("FAIL exu5_wen got wen=%b rd=%0d expected 1/5", wb_o_reg_wen, wb_o_reg_rd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (decode_o_rs1_busy !== 1'b0 || model_rf[5] !== 32'h1234_5678 || wb_o_reg_wen !== 1'b0) begin
            errors++;
            $display("FAIL exu5_commit got busy=%b rf=%h wen=%b expected 0/12345678/0",
                     decode_o_rs1_busy, model_rf[5], wb_o_reg_wen);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] ed;
        logic [31:0] ld;
        logic        exp_exu;
        @(negedge clk);
        ed = 32'h0000_AAAA;
        ld = 32'h0000_BBBB;
        exu_i_valid = 1'b1;
        exu_i_rd    = 5'd3;
        lsu_i_valid = 1'b1;
        lsu_i_rd    = 5'd4;
        for (int i = 0; i < 4; i++) begin
            exu_i_data = ed;
            lsu_i_data = ld;
            #1;
`ifdef WB_ARB_RR_EN
            exp_exu = (i % 2 == 0);
`else
            exp_exu = 1'b0;
`endif
            checks++;
            if (exu_o_ready !== exp_exu || lsu_o_ready !== !exp_exu) begin
                errors++;
                $display("FAIL arb_cycle%0d got exu_ready=%b lsu_ready=%b expected %b/%b",
                         i, exu_o_ready, lsu_o_ready, exp_exu, !exp_exu);
            end
            if (exp_exu) begin
                exp_q.push_back({5'd3, ed});
                ed = ed + 32'h0001_0000;
            end else begin
                exp_q.push_back({5'd4, ld});
                ld = ld + 32'h0001_0000;
            end
            @(negedge clk);
        end
        exu_i_valid = 1'b0;
        lsu_i_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rd0_write();
        logic [31:0] d;
        @(negedge clk);
        decode_i_issue_valid = 1'b1;
        decode_i_issue_rd    = 5'd12;
        @(negedge clk);
        decode_i_issue_valid = 1'b0;
        exu_i_valid = 1'b1;
        exu_i_rd    = 5'd0;
        exu_i_data  = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (exu_o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_grant got %b expected 1", exu_o_ready);
        end
        @(posedge clk);
        #1;
        exu_i_valid      = 1'b0;
        decode_i_reg_rs1 = 5'd12;
        decode_i_reg_rs2 = 5'd0;
        #1;
        checks++;
        if (wb_o_reg_wen !== 1'b0 || decode_o_rs1_busy !== 1'b1 || decode_o_rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL rd0_nowrite got wen=%b busy12=%b busy0=%b expected 0/1/0",
                     wb_o_reg_wen, decode_o_rs1_busy, decode_o_rs2_busy);
        end
        @(negedge clk);
        d = $urandom;
        lsu_i_valid = 1'b1;
        lsu_i_rd    = 5'd12;
        lsu_i_data  = d;
        exp_q.push_back({5'd12, d});
        @(posedge clk);
        #1;
        lsu_i_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (decode_o_rs1_busy !== 1'b0 || model_rf[12] !== d) begin
            errors++;
            $display("FAIL lsu12_commit got busy=%b rf=%h expected 0/%h", decode_o_rs1_busy, model_rf[12], d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            exu_i_valid = 1'b1;
            exu_i_rd    = 5'(16 + $urandom_range(0, 15));
            exu_i_data  = d;
            exp_q.push_back({exu_i_rd, d});
            #1;
            checks++;
            if (exu_o_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant%0d got %b expected 1", i, exu_o_ready);
            end
            @(negedge clk);
        end
        exu_i_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        decode_i_issue_valid = 1'b1;
        decode_i_issue_rd    = 5'd7;
        decode_i_reg_rs1     = 5'd7;
        @(negedge clk);
        decode_i_issue_valid = 1'b0;
        exu_i_valid = 1'b1;
        exu_i_rd    = 5'd7;
        exu_i_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        exu_i_valid = 1'b0;
        checks++;
        if (wb_o_reg_wen !== 1'b1 || wb_o_reg_rd !== 5'd7) begin
            errors++;
            $display("FAIL rst_mid_pre got wen=%b rd=%0d expected 1/7", wb_o_reg_wen, wb_o_reg_rd);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (wb_o_reg_wen !== 1'b0 || wb_o_reg_rd !== 5'd0 || wb_o_reg_data !== 32'd0 || decode_o_rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async got wen=%b rd=%0d data=%h busy7=%b expected 0/0/0/0",
                     wb_o_reg_wen, wb_o_reg_rd, wb_o_reg_data, decode_o_rs1_busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (model_rf[7] !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_nocommit got rf7=%h expected 0", model_rf[7]);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_issue_stall();
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        decode_i_issue_valid = 1'b1;
        decode_i_issue_rd    = 5'd9;
        decode_i_reg_rs1     = 5'd9;
        @(negedge clk);
        exu_i_valid = 1'b1;
        exu_i_rd    = 5'd9;
        exu_i_data  = d;
        exp_q.push_back({5'd9, d});
        #1;
        checks++;
        if (decode_o_issue_ready !== 1'b0 || exu_o_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall9_grant got issue_ready=%b exu_ready=%b expected 0/1", decode_o_issue_ready, exu_o_ready);
        end
        @(posedge clk);
        #1;
        exu_i_valid = 1'b0;
        checks++;
        if (wb_o_reg_wen !== 1'b1 || decode_o_issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall9_wen got wen=%b issue_ready=%b expected 1/0", wb_o_reg_wen, decode_o_issue_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (decode_o_issue_ready !== 1'b1 || model_rf[9] !== d) begin
            errors++;
            $display("FAIL stall9_commit got issue_ready=%b rf9=%h expected 1/%h", decode_o_issue_ready, model_rf[9], d);
        end
        @(posedge clk);
        #1;
        decode_i_issue_valid = 1'b0;
        #1;
        checks++;
        if (decode_o_rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL stall9_reissue got busy=%b expected 1", decode_o_rs1_busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_issue_write();
        test_arbitration();
        test_rd0_write();
        test_back_to_back();
        test_reset_mid();
        test_issue_stall();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
